// File: rtl/rambyte_hs_pkg.sv
// Shared types and helpers for the rambyte_hs byte-masked RAM.
// Macro RAMBYTE_HS_INIT_EN (used by rambyte_hs) enables the post-reset array clear.
package rambyte_hs_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int RD_OLD = 0;
    localparam int RD_NEW = 1;

    // Widest word / lane count the merge helper accepts; callers zero-extend.
    localparam int MAX_DW = 256;
    localparam int MAX_NL = 256;

    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0] d_old,
        input logic [MAX_DW-1:0] d_new,
        input logic [MAX_NL-1:0] mask,
        input int                bw
    );
        logic [MAX_DW-1:0] r;
        logic [7:0]        li;
        r = d_old;
        for (int i = 0; i < MAX_DW; i++) begin
            li   = 8'(i / bw);
            r[i] = mask[li] ? d_new[i] : d_old[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rambyte_hs_array.sv
// Single-port storage with per-lane write mask, registered read and a clear port.
// The read register doubles as the response data register of the top level.
module rambyte_hs_array
    import rambyte_hs_pkg::*;
#(
    parameter  int DW      = 32,
    parameter  int AW      = 10,
    parameter  int BW      = 8,
    parameter  int WRFIRST = RD_OLD,
    localparam int NL      = DW / BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [NL-1:0] i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_din,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0]     r_mem [2**AW];
    logic [DW-1:0]     r_rdata;

    logic [DW-1:0]     w_old;
    logic [DW-1:0]     w_merged;
    logic [MAX_DW-1:0] w_old_ext;
    logic [MAX_DW-1:0] w_din_ext;
    logic [MAX_DW-1:0] w_merged_ext;
    logic [MAX_NL-1:0] w_we_ext;
    logic              w_unused_merge;

    always_comb begin
        w_old                = r_mem[i_addr];
        w_old_ext            = '0;
        w_old_ext[DW-1:0]    = w_old;
        w_din_ext            = '0;
        w_din_ext[DW-1:0]    = i_din;
        w_we_ext             = '0;
        w_we_ext[NL-1:0]     = i_we;
        w_merged_ext         = lane_merge(w_old_ext, w_din_ext, w_we_ext, BW);
        w_merged             = w_merged_ext[DW-1:0];
    end

    assign w_unused_merge = ^w_merged_ext;

    // Clear has priority; the top never asserts both in the same cycle.
    always_ff @(posedge clk) begin
        if (i_clr_en) begin
            r_mem[i_clr_addr] <= '0;
        end else if (i_en) begin
            for (int l = 0; l < NL; l++) begin
                if (i_we[l]) begin
                    r_mem[i_addr][l*BW +: BW] <= i_din[l*BW +: BW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= (WRFIRST == RD_NEW) ? w_merged : w_old;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rambyte_hs.sv
// Byte-masked RAM with valid/ready request and response channels.
// Define RAMBYTE_HS_INIT_EN to zero the whole array after every reset.
module rambyte_hs
    import rambyte_hs_pkg::*;
#(
    parameter  int DW      = 32,
    parameter  int AW      = 10,
    parameter  int BW      = 8,
    parameter  int WRFIRST = RD_OLD,
    localparam int NL      = DW / BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [NL-1:0] req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_din,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dout,
    output logic          init_done
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rsp_valid;
    logic          w_accept;
    logic          w_clr_en;
    logic [AW-1:0] w_clr_addr;

`ifdef RAMBYTE_HS_INIT_EN
    localparam logic [AW-1:0] CNT_LAST = '1;
    logic [AW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == INIT) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
`ifdef RAMBYTE_HS_INIT_EN
            INIT:    if (r_cnt == CNT_LAST) w_state_nxt = RUN;
`else
            INIT:    w_state_nxt = RUN;
`endif
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == RUN) && (!r_rsp_valid || rsp_ready);
        init_done  = (r_state == RUN);
`ifdef RAMBYTE_HS_INIT_EN
        w_clr_en   = (r_state == INIT);
        w_clr_addr = r_cnt;
`else
        w_clr_en   = 1'b0;
        w_clr_addr = '0;
`endif
    end

    assign w_accept = req_valid && req_ready;

    // A new accept keeps the response valid even while the old one is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;

    rambyte_hs_array #(
        .DW      (DW),
        .AW      (AW),
        .BW      (BW),
        .WRFIRST (WRFIRST)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_accept),
        .i_we       (req_we),
        .i_addr     (req_addr),
        .i_din      (req_din),
        .i_clr_en   (w_clr_en),
        .i_clr_addr (w_clr_addr),
        .o_rdata    (rsp_dout)
    );

endmodule

// File: tb/tb_rambyte_hs.sv
// Scoreboard bench for rambyte_hs: one instance per read-during-write mode, shared stimulus.
module tb_rambyte_hs;

`ifdef RAMBYTE_HS_INIT_EN
    localparam int INIT_CYC = 16;
`else
    localparam int INIT_CYC = 1;
`endif
    localparam logic [1:0] HALF_READY = (INIT_CYC > 8) ? 2'b00 : 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b1;
    logic [3:0]  req_we = '0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_din = '0;

    logic        req_ready0, rsp_valid0, init_done0;
    logic        req_ready1, rsp_valid1, init_done1;
    logic [31:0] rsp_dout0, rsp_dout1;

    always #5 clk = ~clk;

    rambyte_hs #(.DW(32), .AW(4), .BW(8), .WRFIRST(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout0),
        .init_done(init_done0)
    );

    rambyte_hs #(.DW(32), .AW(4), .BW(8), .WRFIRST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout1),
        .init_done(init_done1)
    );

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        m_e0, m_e1;
    logic [31:0] mdl [16];
    int          checks = 0;
    int          failures = 0;
    int          waits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) r[l*8 +: 8] = n[l*8 +: 8];
        end
        return r;
    endfunction

    // Monitor: compares every consumed response against the queued expectation.
    always begin
        @(negedge clk);
        #2;
        if (!rst && rsp_valid0 && rsp_ready) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp0_unexpected actual=%h required=none", rsp_dout0);
            end else begin
                m_e0 = q0.pop_front();
                if (m_e0.chk) check("rsp0_data", rsp_dout0, m_e0.data);
            end
        end
        if (!rst && rsp_valid1 && rsp_ready) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp1_unexpected actual=%h required=none", rsp_dout1);
            end else begin
                m_e1 = q1.pop_front();
                if (m_e1.chk) check("rsp1_data", rsp_dout1, m_e1.data);
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic do_req(input logic [3:0] we, input logic [3:0] addr, input logic [31:0] din,
                          input logic c0, input logic [31:0] e0, input logic [31:0] e1);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_din   = din;
        #1;
        while (!(req_ready0 && req_ready1) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        waits += n;
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL req_accept_timeout actual=stalled required=accepted");
        end else begin
            q0.push_back(exp_t'{c0, e0});
            q1.push_back(exp_t'{1'b1, e1});
            mdl[addr] = mrg(mdl[addr], din, we);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        check({tag, "_rsp_valid"}, 32'({rsp_valid1, rsp_valid0}), 32'd0);
        check({tag, "_rsp_dout0"}, rsp_dout0, 32'd0);
        check({tag, "_rsp_dout1"}, rsp_dout1, 32'd0);
        check({tag, "_init_done"}, 32'({init_done1, init_done0}), 32'd0);
        check({tag, "_req_ready"}, 32'({req_ready1, req_ready0}), 32'd0);
    endtask

    // Called on the falling edge where rst is released.
    task automatic init_wait(input string name);
        int n;
        n = 0;
        #1;
        while (!(req_ready0 && req_ready1) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(n), 32'(INIT_CYC));
        check({name, "_done"}, 32'({init_done1, init_done0}), 32'd3);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r_we, r_a;
        logic [31:0] r_d;

        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk_rst("reset");
        @(negedge clk);
        rst = 1'b0;
        init_wait("init_cycles");

`ifdef RAMBYTE_HS_INIT_EN
        for (int a = 0; a < 16; a++) do_req(4'h0, 4'(a), 32'h0, 1'b1, 32'h0, 32'h0);
`else
        // Full-mask writes: write-first mode must echo din exactly.
        for (int a = 0; a < 16; a++) do_req(4'hF, 4'(a), 32'h0, 1'b0, 32'h0, 32'h0);
`endif

        do_req(4'hF, 4'd3, 32'hAABBCCDD, 1'b1, 32'h00000000, 32'hAABBCCDD);
        do_req(4'h5, 4'd3, 32'h11223344, 1'b1, 32'hAABBCCDD, 32'hAA22CC44);
        do_req(4'h0, 4'd3, 32'h00000000, 1'b1, 32'hAA22CC44, 32'hAA22CC44);
        do_req(4'h3, 4'd5, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h0000FFFF);
        do_req(4'hF, 4'd7, 32'hCAFEF00D, 1'b1, 32'h00000000, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        do_req(4'h0, 4'd5, 32'h0, 1'b1, 32'h0000FFFF, 32'h0000FFFF);
        req_valid = 1'b1;
        req_we    = 4'hF;
        req_addr  = 4'd6;
        req_din   = 32'h12345678;
        repeat (5) begin
            #1;
            check("bp_req_ready", 32'({req_ready1, req_ready0}), 32'd0);
            check("bp_rsp_valid", 32'({rsp_valid1, rsp_valid0}), 32'd3);
            check("bp_dout0", rsp_dout0, 32'h0000FFFF);
            check("bp_dout1", rsp_dout1, 32'h0000FFFF);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        do_req(4'hF, 4'd6, 32'h12345678, 1'b1, 32'h00000000, 32'h12345678);

        waits = 0;
        for (int i = 0; i < 64; i++) begin
            r_we = 4'($urandom_range(0, 15));
            r_a  = 4'($urandom_range(0, 15));
            r_d  = $urandom;
            do_req(r_we, r_a, r_d, 1'b1, mdl[r_a], mrg(mdl[r_a], r_d, r_we));
        end
        check("stream_bubbles", 32'(waits), 32'd0);
        repeat (3) @(negedge clk);
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);

        // Reset with a response pending and unconsumed.
        rsp_ready = 1'b0;
        do_req(4'h0, 4'd3, 32'h0, 1'b0, 32'h0, mdl[3]);
        #1;
        check("pre_rst_rsp_valid", 32'({rsp_valid1, rsp_valid0}), 32'd3);
        rst = 1'b1;
        #1;
        chk_rst("midrun_rst");
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("half_init_ready", 32'({req_ready1, req_ready0}), 32'(HALF_READY));
        rst = 1'b1;
        #1;
        chk_rst("midinit_rst");
        @(negedge clk);
        rst = 1'b0;
`ifdef RAMBYTE_HS_INIT_EN
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
`endif
        rsp_ready = 1'b1;
        init_wait("reinit_cycles");
        do_req(4'h0, 4'd3, 32'h0, 1'b1, mdl[3], mdl[3]);
        do_req(4'h0, 4'd6, 32'h0, 1'b1, mdl[6], mdl[6]);
        repeat (3) @(negedge clk);
        check("final_q0", 32'(q0.size()), 32'd0);
        check("final_q1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
